// File: rtl/ft245_pkg.sv
// Shared definitions for the FT245 receive path: word width, idle-timeout default
// and the out_count encoding (1..4 valid bytes, 0 = no word).
package ft245_pkg;

  localparam int FT245_RX_WORD_W        = 32;
  localparam int FT245_IDLE_TIMEOUT_DEF = 16;

  typedef logic [2:0] ft245_count_t;

  localparam ft245_count_t FT245_CNT_NONE = 3'd0;
  localparam ft245_count_t FT245_CNT_FULL = 3'd4;

  // Byte lane for the next byte; big-endian mirrors lane n to lane 3-n.
  function automatic logic [1:0] ft245_lane_sel(input logic [1:0] lane, input logic big_endian);
    return big_endian ? ~lane : lane;
  endfunction

endpackage

// File: rtl/ft245_byte_packer.sv
// Packs the FT245 receive byte stream into 32-bit words for the receive async FIFO.
// Partial words are flushed on a new frame, on idle timeout, or on request.
module ft245_byte_packer
  import ft245_pkg::*;
#(
  parameter int IDLE_TIMEOUT = FT245_IDLE_TIMEOUT_DEF,
  parameter bit BIG_ENDIAN   = 1'b0
) (
  input  logic                       ftdi_clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  input  logic                       in_sof,
  input  logic                       flush,
  output logic                       out_wr,
  input  logic                       out_full,
  output logic [FT245_RX_WORD_W-1:0] out_data,
  output logic                       out_sof,
  output ft245_count_t               out_count,
  output logic [15:0]                frame_count
);

  localparam logic [7:0] IDLE_TC = 8'(IDLE_TIMEOUT);

  logic [FT245_RX_WORD_W-1:0] acc;
  ft245_count_t               lanes;
  logic                       acc_sof;
  logic                       out_valid;
  logic                       flush_pend;
  logic [7:0]                 idle_cnt;

  logic       held;
  logic       full_word;
  logic       sof_break;
  logic       accept;
  logic       out_free;
  logic       flush_now;
  logic       commit_req;
  logic       commit;
  logic [1:0] lane_sel;

  always_comb begin
    held       = (lanes != FT245_CNT_NONE);
    full_word  = (lanes == FT245_CNT_FULL);
    // A frame-start byte waits one cycle so it never joins an older partial word.
    sof_break  = in_valid && in_sof && held;
    in_ready   = !rst && !full_word && !sof_break;
    accept     = in_valid && in_ready;
    out_wr     = !rst && out_valid && !out_full;
    out_free   = !out_valid || out_wr;
    flush_now  = held && (flush || flush_pend);
    commit_req = full_word || flush_now || (held && ((idle_cnt == IDLE_TC) || sof_break));
    // An accepted byte always lands first; a coincident flush commits next cycle.
    commit     = out_free && !accept && commit_req;
    lane_sel   = ft245_lane_sel(lanes[1:0], BIG_ENDIAN);
  end

  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      acc         <= '0;
      lanes       <= FT245_CNT_NONE;
      acc_sof     <= 1'b0;
      idle_cnt    <= 8'd0;
      flush_pend  <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sof     <= 1'b0;
      out_count   <= FT245_CNT_NONE;
      frame_count <= 16'd0;
    end else begin
      if (out_wr && out_sof) begin
        frame_count <= frame_count + 16'd1;
      end

      if (commit) begin
        out_data   <= acc;
        out_sof    <= acc_sof;
        out_count  <= lanes;
        out_valid  <= 1'b1;
        acc        <= '0;
        lanes      <= FT245_CNT_NONE;
        acc_sof    <= 1'b0;
        flush_pend <= 1'b0;
      end else begin
        if (out_wr) begin
          out_valid <= 1'b0;
        end
        if (flush_now) begin
          flush_pend <= 1'b1;
        end
        if (accept) begin
          acc[{lane_sel, 3'b000} +: 8] <= in_data;
          if (!held) begin
            acc_sof <= in_sof;
          end
          lanes <= lanes + 3'd1;
        end
      end

      if (commit || accept || !held) begin
        idle_cnt <= 8'd0;
      end else if (idle_cnt != IDLE_TC) begin
        idle_cnt <= idle_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ft245_byte_packer.sv
// Bench for ft245_byte_packer: little- and big-endian instances share one stimulus
// stream; a byte-queue model predicts every written word.
module tb_ft245_byte_packer;

  localparam int TO = 16;

  logic        ftdi_clk = 1'b0;
  logic        rst      = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data  = 8'h00;
  logic        in_sof   = 1'b0;
  logic        flush    = 1'b0;
  logic        out_full = 1'b0;

  logic        in_ready, out_wr, out_sof;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic [15:0] frame_count;
  logic        in_ready_be, out_wr_be, out_sof_be;
  logic [31:0] out_data_be;
  logic [2:0]  out_count_be;
  logic [15:0] frame_count_be;

  always #5 ftdi_clk = ~ftdi_clk;

  ft245_byte_packer #(.IDLE_TIMEOUT(TO), .BIG_ENDIAN(1'b0)) dut (
    .ftdi_clk(ftdi_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sof(in_sof), .flush(flush), .out_wr(out_wr),
    .out_full(out_full), .out_data(out_data), .out_sof(out_sof),
    .out_count(out_count), .frame_count(frame_count));

  ft245_byte_packer #(.IDLE_TIMEOUT(TO), .BIG_ENDIAN(1'b1)) dut_be (
    .ftdi_clk(ftdi_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_be),
    .in_data(in_data), .in_sof(in_sof), .flush(flush), .out_wr(out_wr_be),
    .out_full(out_full), .out_data(out_data_be), .out_sof(out_sof_be),
    .out_count(out_count_be), .frame_count(frame_count_be));

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic [2:0]  cnt;
  } word_t;

  word_t      exp_le[$];
  word_t      exp_be[$];
  logic [7:0] part[$];
  logic       part_sof = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_wr  = 0;
  int         fc_le = 0;
  int         fc_be = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Model: close the held partial word, producing both byte orders.
  function automatic void model_emit();
    word_t wl, wb;
    if (part.size() == 0) return;
    wl = '0;
    wb = '0;
    for (int i = 0; i < part.size(); i++) begin
      wl.data[8*i +: 8]     = part[i];
      wb.data[8*(3-i) +: 8] = part[i];
    end
    wl.sof = part_sof;
    wb.sof = part_sof;
    wl.cnt = 3'(part.size());
    wb.cnt = 3'(part.size());
    exp_le.push_back(wl);
    exp_be.push_back(wb);
    part.delete();
  endfunction

  function automatic void model_accept(input logic [7:0] d, input logic s);
    if (s && part.size() != 0) model_emit();
    if (part.size() == 0) part_sof = s;
    part.push_back(d);
    if (part.size() == 4) model_emit();
  endfunction

  always @(negedge ftdi_clk) begin : mon
    word_t w;
    if (out_wr) begin
      n_wr++;
      if (exp_le.size() == 0) check("le_unexpected_wr", {31'd0, out_wr}, 32'd0);
      else begin
        w = exp_le.pop_front();
        check("le_data", out_data, w.data);
        check("le_sof", {31'd0, out_sof}, {31'd0, w.sof});
        check("le_count", {29'd0, out_count}, {29'd0, w.cnt});
        check("le_frame_count", {16'd0, frame_count}, {16'd0, 16'(fc_le)});
        if (w.sof) fc_le++;
      end
    end
    if (out_wr_be) begin
      if (exp_be.size() == 0) check("be_unexpected_wr", {31'd0, out_wr_be}, 32'd0);
      else begin
        w = exp_be.pop_front();
        check("be_data", out_data_be, w.data);
        check("be_sof", {31'd0, out_sof_be}, {31'd0, w.sof});
        check("be_count", {29'd0, out_count_be}, {29'd0, w.cnt});
        check("be_frame_count", {16'd0, frame_count_be}, {16'd0, 16'(fc_be)});
        if (w.sof) fc_be++;
      end
    end
  end

  task automatic tick();
    @(posedge ftdi_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Present one byte until accepted; a stall longer than 8 cycles releases out_full.
  task automatic send(input logic [7:0] d, input logic s);
    int n;
    n = 0;
    model_accept(d, s);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    @(negedge ftdi_clk);
    while (!in_ready && n < 40) begin
      n++;
      tick();
      if (n == 8) out_full = 1'b0;
      @(negedge ftdi_clk);
    end
    check("send_ready_bound", {31'd0, in_ready}, 32'd1);
    check("be_ready_match", {31'd0, in_ready_be}, {31'd0, in_ready});
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic flush_pulse();
    model_emit();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin : stim
    int n, w0, r;

    // Reset state
    repeat (2) @(posedge ftdi_clk);
    @(negedge ftdi_clk);
    check("rst_out_wr", {31'd0, out_wr}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_sof", {31'd0, out_sof}, 32'd0);
    check("rst_out_count", {29'd0, out_count}, 32'd0);
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge ftdi_clk);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Full word, write two cycles after the 4th accept
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    @(negedge ftdi_clk);
    check("t1_wr_n1", {31'd0, out_wr}, 32'd0);
    check("t1_ready_full", {31'd0, in_ready}, 32'd0);
    tick();
    @(negedge ftdi_clk);
    check("t1_wr_n2", {31'd0, out_wr}, 32'd1);
    tick();
    @(negedge ftdi_clk);
    check("t1_frame_count", {16'd0, frame_count}, 32'd1);
    tick();

    // Idle timeout on a 2-byte partial
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    model_emit();
    n = 0;
    do begin
      @(negedge ftdi_clk);
      n++;
    end while (!out_wr && n < 60);
    check("t2_timeout_latency", 32'(n), 32'(TO + 2));
    tick();
    w0 = n_wr;
    idle(30);
    check("t2_no_extra_wr", 32'(n_wr), 32'(w0));

    // Frame start splits a partial word
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b1);
    flush_pulse();
    idle(4);

    // Back-pressure: 12 bytes with the FIFO full
    out_full = 1'b1;
    for (int i = 0; i < 8; i++) send(8'(8'h30 + i), 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h38;
    repeat (6) begin
      @(negedge ftdi_clk);
      check("t4_ready_low", {31'd0, in_ready}, 32'd0);
      check("t4_no_wr", {31'd0, out_wr}, 32'd0);
      check("t4_data_held", out_data, exp_le[0].data);
      tick();
    end
    out_full = 1'b0;
    for (int i = 8; i < 12; i++) send(8'(8'h30 + i), 1'b0);
    idle(4);

    // Flush after 3 bytes, then flush coincident with an accept
    send(8'hA1, 1'b0);
    send(8'hB2, 1'b0);
    send(8'hC3, 1'b0);
    flush_pulse();
    idle(3);
    send(8'h55, 1'b0);
    model_accept(8'h66, 1'b0);
    model_emit();
    in_valid = 1'b1;
    in_data  = 8'h66;
    flush    = 1'b1;
    @(negedge ftdi_clk);
    check("t5_flush_accept_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge ftdi_clk);
    check("t5_commit_cycle_no_wr", {31'd0, out_wr}, 32'd0);
    tick();
    @(negedge ftdi_clk);
    check("t5_wr_after_commit", {31'd0, out_wr}, 32'd1);
    tick();
    idle(2);

    // Reset with a pending word and a 3-byte partial
    out_full = 1'b1;
    send(8'h71, 1'b1);
    send(8'h72, 1'b0);
    send(8'h73, 1'b0);
    send(8'h74, 1'b0);
    send(8'h75, 1'b0);
    send(8'h76, 1'b0);
    send(8'h77, 1'b0);
    idle(2);
    exp_le.delete();
    exp_be.delete();
    part.delete();
    fc_le = 0;
    fc_be = 0;
    rst      = 1'b1;
    out_full = 1'b0;
    @(negedge ftdi_clk);
    check("t6_rst_no_wr", {31'd0, out_wr}, 32'd0);
    check("t6_rst_no_wr_be", {31'd0, out_wr_be}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge ftdi_clk);
    check("t6_out_data", out_data, 32'd0);
    check("t6_out_sof", {31'd0, out_sof}, 32'd0);
    check("t6_out_count", {29'd0, out_count}, 32'd0);
    check("t6_frame_count", {16'd0, frame_count}, 32'd0);
    check("t6_ready", {31'd0, in_ready}, 32'd1);
    tick();
    send(8'h81, 1'b1);
    send(8'h82, 1'b0);
    send(8'h83, 1'b0);
    send(8'h84, 1'b0);
    idle(4);

    // Randomized stream: short gaps, occasional frame starts, flushes and timeouts
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 19);
      out_full = ($urandom_range(0, 3) == 0);
      if (r == 0) begin
        out_full = 1'b0;
        model_emit();
        idle(40);
      end else if (r == 1) begin
        out_full = 1'b0;
        flush_pulse();
      end else begin
        repeat ($urandom_range(0, 2)) tick();
        send(8'($urandom), ($urandom_range(0, 5) == 0));
      end
    end
    out_full = 1'b0;
    flush_pulse();
    idle(30);
    check("end_le_drained", 32'(exp_le.size()), 32'd0);
    check("end_be_drained", 32'(exp_be.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
